// File: rtl/clock_enable_gen.sv
// Multi-channel clock-enable generator driven from the fast PLL clock.
// Each channel is a phase accumulator. Its carry-out becomes a one-cycle
// enable strobe. Rate changes are parked in a pending register and are
// only made active at a phase wrap, so a period is never cut short.
// All strobes stay low until the synchronised PLL lock indication is high.
module clock_enable_gen #(
    parameter int          NUM_CH    = 4,
    parameter int          ACC_W     = 24,
    parameter int          CH_W      = 2,
    parameter int unsigned RESET_INC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              running
);

    localparam logic [ACC_W-1:0] RST_INC = ACC_W'(RESET_INC);

    // Lock synchroniser; running_q is the only lock view the channels use.
    logic lock_meta_q;
    logic running_q;

    // Per-channel state.
    logic [ACC_W-1:0]  acc_q  [NUM_CH];
    logic [ACC_W-1:0]  acc_d  [NUM_CH];
    logic [ACC_W-1:0]  inc_q  [NUM_CH];
    logic [ACC_W-1:0]  inc_d  [NUM_CH];
    logic [ACC_W-1:0]  pend_q [NUM_CH];
    logic [ACC_W-1:0]  pend_d [NUM_CH];
    logic [NUM_CH-1:0] pv_q;
    logic [NUM_CH-1:0] pv_d;
    logic [NUM_CH-1:0] ce_q;
    logic [NUM_CH-1:0] ce_d;

    // Helpers: widened sum (top bit is the carry) and decoded write hit.
    logic [ACC_W:0]    sum [NUM_CH];
    logic [NUM_CH-1:0] hit;
    logic              wr_ok;

    // Writes to a channel that does not exist are dropped.
    assign wr_ok = cfg_we && (32'(cfg_ch) < 32'(NUM_CH));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign sum[g] = {1'b0, acc_q[g]} + {1'b0, inc_q[g]};
        assign hit[g] = wr_ok && (cfg_ch == CH_W'(g));
    end

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            running_q   <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            running_q   <= lock_meta_q;
        end
    end

    // Next-state for every channel: accumulate, strobe, and pick the apply point.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]  = acc_q[i];
            inc_d[i]  = inc_q[i];
            pend_d[i] = pend_q[i];
            pv_d[i]   = pv_q[i];
            ce_d[i]   = 1'b0;

            // Phase: cleared while unlocked or on restart, frozen when disabled.
            if (!running_q || sync_restart) begin
                acc_d[i] = '0;
            end else if (inc_q[i] != '0) begin
                acc_d[i] = sum[i][ACC_W-1:0];
                ce_d[i]  = sum[i][ACC_W];
            end

            if (sync_restart) begin
                // Restart realigns everything, so any new rate can go live now.
                if (hit[i]) begin
                    inc_d[i] = cfg_inc;
                end else if (pv_q[i]) begin
                    inc_d[i] = pend_q[i];
                end
                pv_d[i] = 1'b0;
            end else begin
                // Safe apply points: phase wrap, idle channel, or no lock.
                if (pv_q[i] && (!running_q || (inc_q[i] == '0) || ce_d[i])) begin
                    inc_d[i] = pend_q[i];
                    pv_d[i]  = 1'b0;
                end
                // A write on the same edge as an apply becomes the next pending value.
                if (hit[i]) begin
                    pend_d[i] = cfg_inc;
                    pv_d[i]   = 1'b1;
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= '0;
                inc_q[i]  <= RST_INC;
                pend_q[i] <= '0;
            end
            pv_q <= '0;
            ce_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]  <= acc_d[i];
                inc_q[i]  <= inc_d[i];
                pend_q[i] <= pend_d[i];
            end
            pv_q <= pv_d;
            ce_q <= ce_d;
        end
    end

    // Strobes are masked by running so a lock loss silences them that very cycle.
    assign ce          = ce_q & {NUM_CH{running_q}};
    assign cfg_pending = pv_q;
    assign running     = running_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen (4 channels, 24-bit accumulators).
// A cycle-level reference model tracks each channel's phase as a plain
// number modulo 2**24 and fires a strobe whenever the phase wraps; pending
// rates follow the "last write wins, apply on wrap / idle / unlocked" rules.
// Directed sections check the timing examples; a random section follows.
module tb_clock_enable_gen;

    localparam int     NCH = 4;
    localparam int     AW  = 24;
    localparam int     CW  = 2;
    localparam longint MOD = longint'(1) << AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           pll_locked = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CW-1:0]  cfg_ch = '0;
    logic [AW-1:0]  cfg_inc = '0;
    logic           sync_restart = 1'b0;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] cfg_pending;
    logic           running;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Reference model state.
    longint   m_phase [NCH];
    longint   m_inc   [NCH];
    longint   m_pend  [NCH];
    bit       m_pv    [NCH];
    bit       m_ce    [NCH];
    bit [1:0] m_sync;

    clock_enable_gen #(
        .NUM_CH   (NCH),
        .ACC_W    (AW),
        .CH_W     (CW),
        .RESET_INC(0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_inc     (cfg_inc),
        .sync_restart(sync_restart),
        .ce          (ce),
        .cfg_pending (cfg_pending),
        .running     (running)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_sync = 2'b00;
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0;
            m_inc[c]   = 0;
            m_pend[c]  = 0;
            m_pv[c]    = 1'b0;
            m_ce[c]    = 1'b0;
        end
    endtask

    // One rising edge of the reference model, using the inputs held across it.
    task automatic model_step();
        bit     run;
        bit     hit;
        bit     wrap;
        longint nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        run = m_sync[1];
        for (int c = 0; c < NCH; c++) begin
            hit  = cfg_we && (int'(cfg_ch) == c);
            nxt  = m_phase[c] + m_inc[c];
            wrap = run && !sync_restart && (m_inc[c] != 0) && (nxt >= MOD);
            m_ce[c] = wrap;
            if (!run || sync_restart) m_phase[c] = 0;
            else                      m_phase[c] = nxt % MOD;
            if (sync_restart) begin
                if (hit)         m_inc[c] = longint'(cfg_inc);
                else if (m_pv[c]) m_inc[c] = m_pend[c];
                m_pv[c] = 1'b0;
            end else begin
                if (m_pv[c] && (!run || m_inc[c] == 0 || wrap)) begin
                    m_inc[c] = m_pend[c];
                    m_pv[c]  = 1'b0;
                end
                if (hit) begin
                    m_pend[c] = longint'(cfg_inc);
                    m_pv[c]   = 1'b1;
                end
            end
        end
        m_sync = {m_sync[0], pll_locked};
    endtask

    // Advance one clock: model on the rising edge, compare on the falling edge.
    task automatic step();
        logic [NCH-1:0] exp_ce;
        logic [NCH-1:0] exp_pend;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            exp_ce[c]   = m_ce[c] && m_sync[1];
            exp_pend[c] = m_pv[c];
        end
        check_val("ce", ce, exp_ce);
        check_val("cfg_pending", cfg_pending, exp_pend);
        check_val("running", running, m_sync[1]);
    endtask

    task automatic cfg_write(input int ch, input logic [AW-1:0] val);
        cfg_we  = 1'b1;
        cfg_ch  = CW'(ch);
        cfg_inc = val;
        step();
        cfg_we  = 1'b0;
    endtask

    // Step until channel ch strobes; n is the number of steps taken.
    task automatic wait_ce(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ce[ch] && n < budget);
        if (!ce[ch]) check_val("wait_ce_timeout", ce[ch], 1);
    endtask

    // After a realignment edge, strobes land on multiples of each period.
    task automatic check_pattern(input string tag);
        for (int k = 1; k <= 32; k++) begin
            step();
            check_val({tag, "_ce0"}, ce[0], (k % 4) == 0);
            check_val({tag, "_ce1"}, ce[1], (k % 16) == 0);
            check_val({tag, "_ce3"}, ce[3], (k % 2) == 0);
        end
    endtask

    initial begin
        int n;
        int cnt;
        int last;
        model_reset();

        // Reset state.
        repeat (3) step();
        check_val("rst_ce", ce, 0);
        check_val("rst_pending", cfg_pending, 0);
        check_val("rst_running", running, 0);
        rst_n = 1'b1;

        // Lock gating: ch0 at /4 while unlocked.
        cfg_write(0, 24'h400000);
        repeat (20) step();
        check_val("lock_low_running", running, 0);
        check_val("lock_low_ce", ce, 0);
        pll_locked = 1'b1;
        step();
        check_val("lock_lat_1", running, 0);
        step();
        check_val("lock_lat_2", running, 1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check_val("lock_ce0", ce[0], (k % 4) == 0);
        end

        // Fractional rate f/10 on ch2: count and spacing.
        cfg_write(2, 24'h19999A);
        cnt  = 0;
        last = -1;
        for (int t = 0; t < 20000; t++) begin
            step();
            if (ce[2]) begin
                if (last >= 0) check_val("frac_gap_9_or_10", (t - last == 9) || (t - last == 10), 1);
                last = t;
                cnt++;
            end
        end
        check_val("frac_count_2000pm1", (cnt >= 1999) && (cnt <= 2001), 1);

        // Runtime reprogram of ch1 from /4 to /16 mid-period.
        cfg_write(1, 24'h400000);
        wait_ce(1, 64, n);
        repeat (2) step();
        cfg_write(1, 24'h100000);
        check_val("reprog_pend_set", cfg_pending[1], 1);
        for (int k = 0; k < 8; k++) begin
            step();
            if (ce[1]) break;
            check_val("reprog_pend_hold", cfg_pending[1], 1);
        end
        check_val("reprog_apply_ce", ce[1], 1);
        check_val("reprog_apply_clr", cfg_pending[1], 0);
        wait_ce(1, 64, n);
        check_val("reprog_gap_a", n, 16);
        wait_ce(1, 64, n);
        check_val("reprog_gap_b", n, 16);

        // Disable then re-enable ch3.
        cfg_write(3, 24'h400000);
        wait_ce(3, 64, n);
        cfg_write(3, 24'h000000);
        wait_ce(3, 8, n);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ce[3]) cnt++;
        end
        check_val("disable_silent", cnt, 0);
        cfg_write(3, 24'h800000);
        check_val("enable_pend_hi", cfg_pending[3], 1);
        step();
        check_val("enable_pend_lo", cfg_pending[3], 0);
        for (int k = 0; k < 3; k++) begin
            wait_ce(3, 8, n);
            check_val("enable_gap_2", n, 2);
        end

        // sync_restart realignment, then a short lock loss.
        repeat (7) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check_val("restart_ce_zero", ce, 0);
        check_pattern("restart");
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        check_val("lockloss_running", running, 0);
        check_val("lockloss_ce", ce, 0);
        n = 0;
        do begin
            step();
            n++;
        end while (!running && n < 10);
        check_val("relock_running", running, 1);
        check_pattern("relock");

        // Randomised traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_ch = CW'($urandom_range(0, NCH - 1));
            case ($urandom_range(0, 3))
                0:       cfg_inc = '0;
                1:       cfg_inc = AW'($urandom_range(24'h100000, 24'h800000));
                2:       cfg_inc = AW'($urandom_range(0, 24'hFFFFFF));
                default: cfg_inc = AW'(24'h400000 >> $urandom_range(0, 4));
            endcase
            sync_restart = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) pll_locked = ~pll_locked;
            step();
        end
        cfg_we       = 1'b0;
        sync_restart = 1'b0;
        pll_locked   = 1'b1;

        // Async reset between edges while channels are active.
        cfg_write(0, 24'h800000);
        cfg_write(3, 24'hC00000);
        repeat (12) step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("arst_ce", ce, 0);
        check_val("arst_pending", cfg_pending, 0);
        check_val("arst_running", running, 0);
        step();
        rst_n = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!running && n < 10);
        check_val("arst_relock", running, 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ce != '0) cnt++;
        end
        check_val("arst_reset_inc_idle", cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
